// File: rtl/lfsr_card_rng.sv
// Card-value generator: a free-running Fibonacci LFSR sampled on request, with range
// rejection, a bounded retry count, a deterministic fallback value and runtime reseeding.
module lfsr_card_rng #(
   parameter int unsigned           WIDTH     = 16,
   parameter logic [WIDTH-1:0]      TAPS      = WIDTH'(16'hB400),
   parameter logic [WIDTH-1:0]      SEED      = WIDTH'(16'h000F),
   parameter int unsigned           OUT_W     = 4,
   parameter int unsigned           FIELD_LSB = 6,
   parameter int unsigned           MIN_VAL   = 1,
   parameter int unsigned           MAX_VAL   = 13,
   parameter int unsigned           MAX_TRIES = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic             busy,
   output logic             valid,
   output logic [OUT_W-1:0] value,
   output logic             fallback
);

   localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam int unsigned SPAN  = MAX_VAL - MIN_VAL + 1;

   // Parameter sanity, rejected at elaboration
   if (WIDTH < 4) begin : g_chk_width
      $fatal(1, "lfsr_card_rng: WIDTH must be >= 4");
   end
   if (MIN_VAL > MAX_VAL) begin : g_chk_range
      $fatal(1, "lfsr_card_rng: MIN_VAL must not exceed MAX_VAL");
   end
   if (MAX_VAL >= (1 << OUT_W)) begin : g_chk_outw
      $fatal(1, "lfsr_card_rng: MAX_VAL does not fit in OUT_W bits");
   end
   if (FIELD_LSB + OUT_W > WIDTH) begin : g_chk_field
      $fatal(1, "lfsr_card_rng: candidate field exceeds LFSR width");
   end
   if (SEED == '0) begin : g_chk_seed
      $fatal(1, "lfsr_card_rng: SEED must be nonzero");
   end
   if (MAX_TRIES < 1) begin : g_chk_tries
      $fatal(1, "lfsr_card_rng: MAX_TRIES must be >= 1");
   end

   typedef enum logic {S_IDLE, S_DRAW} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d, step_raw, step_c;
   logic [TRY_W-1:0] tries_q, tries_d;
   logic             busy_d, valid_d, fallback_d;
   logic [OUT_W-1:0] value_d, cand, fb_val;
   logic             cand_ok, last_try;

   // LFSR step with zero guard; a runtime seed overrides the step
   always_comb begin
      step_raw = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
      step_c   = (step_raw == '0) ? SEED : step_raw;
      if (seed_load) begin
         lfsr_d = (seed_in == '0) ? SEED : seed_in;
      end else begin
         lfsr_d = step_c;
      end
   end

   // Candidate taken from the freshly stepped register
   always_comb begin
      cand     = step_c[FIELD_LSB +: OUT_W];
      cand_ok  = (32'(cand) >= MIN_VAL) && (32'(cand) <= MAX_VAL);
      fb_val   = OUT_W'(MIN_VAL + (32'(cand) % SPAN));
      last_try = (tries_q == TRY_W'(MAX_TRIES - 1));
   end

   // Draw control: next state and next registered outputs
   always_comb begin
      state_d    = state_q;
      tries_d    = tries_q;
      busy_d     = busy;
      valid_d    = 1'b0;
      value_d    = value;
      fallback_d = fallback;
      case (state_q)
         S_IDLE: begin
            // A request landing in the valid cycle is dropped, not queued
            if (req && !valid) begin
               state_d = S_DRAW;
               tries_d = '0;
               busy_d  = 1'b1;
            end
         end
         S_DRAW: begin
            if (!seed_load) begin
               if (cand_ok) begin
                  value_d    = cand;
                  fallback_d = 1'b0;
                  valid_d    = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = S_IDLE;
               end else if (last_try) begin
                  value_d    = fb_val;
                  fallback_d = 1'b1;
                  valid_d    = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  tries_d = tries_q + TRY_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         lfsr_q   <= SEED;
         tries_q  <= '0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         value    <= OUT_W'(MIN_VAL);
         fallback <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         tries_q  <= tries_d;
         busy     <= busy_d;
         valid    <= valid_d;
         value    <= value_d;
         fallback <= fallback_d;
      end
   end

endmodule
